// File: rtl/if_stage_pkg.sv
// if_stage_pkg: pipeline bus widths and reset vector shared by the IF and ID stages
package if_stage_pkg;
  localparam int FS_TO_DS_BUS_WD = 64;
  localparam int BR_BUS_WD = 33;
  localparam int DS_TO_ES_BUS_WD = 150;
  localparam logic [31:0] RESET_PC = 32'h1c000000;
endpackage

// File: rtl/if_stage.sv
// if_stage: instruction fetch with PC/next-PC generation, sync SRAM request and a one-entry hold buffer
module if_stage
  import if_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_en,
  output logic                       inst_sram_we,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic [31:0]                inst_sram_rdata
);
  logic        to_fs_valid_q;
  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_q, buf_d;
  logic        br_taken, fs_allowin;
  logic [31:0] br_target, nextpc;
  assign br_taken = br_bus[32];
  assign br_target = br_bus[31:0];
  assign nextpc = br_taken ? br_target : fs_pc_q + 32'd4;
  assign fs_allowin = !fs_valid_q || ds_allowin || br_taken;
  assign fs_to_ds_valid = fs_valid_q && !br_taken;
  assign inst_sram_en = to_fs_valid_q && fs_allowin;
  assign inst_sram_we = 1'b0;
  assign inst_sram_addr = nextpc;
  assign inst_sram_wdata = 32'd0;
  assign fs_to_ds_bus = {fs_pc_q, buf_valid_q ? buf_q : inst_sram_rdata};
  always_comb begin
    fs_pc_d = inst_sram_en ? nextpc : fs_pc_q;
    fs_valid_d = inst_sram_en ? 1'b1 : (fs_allowin ? 1'b0 : fs_valid_q);
    // the SRAM word is only valid for one cycle, so park it the first cycle ID stalls
    buf_valid_d = fs_allowin ? 1'b0 : (fs_valid_q ? 1'b1 : buf_valid_q);
    buf_d = (fs_valid_q && !fs_allowin && !buf_valid_q) ? inst_sram_rdata : buf_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      to_fs_valid_q <= 1'b0;
      fs_valid_q <= 1'b0;
      fs_pc_q <= RESET_PC - 32'd4;
      buf_valid_q <= 1'b0;
      buf_q <= 32'd0;
    end else begin
      to_fs_valid_q <= 1'b1;
      fs_valid_q <= fs_valid_d;
      fs_pc_q <= fs_pc_d;
      buf_valid_q <= buf_valid_d;
      buf_q <= buf_d;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed plus random fetch-stage checks against an instruction-stream reference model
module tb_if_stage;
  import if_stage_pkg::*;
  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allowin;
  logic [32:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_en, inst_sram_we;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic [31:0] sram_q = 32'd0;
  logic [31:0] garbage = 32'd0;
  logic        garble = 1'b0;
  int          checks = 0;
  int          passed = 0;
  logic        m_valid, m_started, stall_next;
  logic [31:0] m_pc;

  if_stage dut (
    .clk(clk), .reset(reset), .ds_allowin(ds_allowin), .br_bus(br_bus),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a3c3c ^ (a * 32'd2654435761);
  endfunction

  // SRAM returns the word a cycle after the request; while ID stalls it is scrambled
  always @(posedge clk) if (inst_sram_en) sram_q <= mem(inst_sram_addr);
  assign inst_sram_rdata = garble ? garbage : sram_q;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step(input logic r, input logic a, input logic b, input logic [31:0] t);
    logic ev, een;
    logic [31:0] eaddr;
    @(posedge clk);
    #1;
    reset = r;
    ds_allowin = a;
    br_bus = {b, t};
    garbage = $urandom;
    garble = stall_next;
    @(negedge clk);
    ev = m_valid && !b;
    een = m_started && (!m_valid || a || b);
    eaddr = b ? t : m_pc + 32'd4;
    check("valid", {63'd0, fs_to_ds_valid}, {63'd0, ev});
    check("en", {63'd0, inst_sram_en}, {63'd0, een});
    check("we_wdata", {31'd0, inst_sram_we, inst_sram_wdata}, 64'd0);
    if (een) check("addr", {32'd0, inst_sram_addr}, {32'd0, eaddr});
    if (ev) check("bus", fs_to_ds_bus, {m_pc, mem(m_pc)});
    stall_next = !r && m_valid && !a && !b;
    if (r) begin
      m_valid = 1'b0;
      m_pc = RESET_PC - 32'd4;
      m_started = 1'b0;
    end else begin
      if (een) begin
        m_pc = eaddr;
        m_valid = 1'b1;
      end else if (!m_valid || a || b) m_valid = 1'b0;
      m_started = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b1;
    ds_allowin = 1'b1;
    br_bus = 33'd0;
    m_valid = 1'b0;
    m_started = 1'b0;
    m_pc = RESET_PC - 32'd4;
    stall_next = 1'b0;
    @(posedge clk);
    repeat (3) step(1, 1, 0, 0);
    repeat (4) step(0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 32'h1c000100);
    repeat (2) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h1c000200);
    repeat (3) step(0, 1, 0, 0);
    step(0, 1, 1, 32'hfffffffc);
    repeat (3) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (4) step(0, 1, 0, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(63) == 0, $urandom_range(9) < 7, $urandom_range(7) == 0,
           $urandom_range(3) == 0 ? $urandom : RESET_PC + {$urandom_range(255), 2'b00});
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
